// File: rtl/demux4_buf.sv
// ---------------------------------------------------------------------------
// demux4_buf
//   Buffered 1:4 steering block. It is the inverse of a 4:1 datapath mux: one
//   WIDTH-bit source word is routed to one of four destination channels chosen
//   by s, and each channel owns an independent 2-entry FIFO.
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   rst_n            synchronous active-low reset
//   i [WIDTH-1:0]    source data word
//   s [1:0]          destination channel select (0..3)
//   in_valid         source offers i to channel s this cycle
//   in_ready         channel s can accept a word this cycle (combinational)
//   o0..o3           head word of channel k, all-zero while the channel is empty
//   v0..v3           channel k holds at least one word (registered)
//   ack0..ack3       sink k consumes the head word of channel k
//   full0..full3     channel k holds two words (registered)
// ---------------------------------------------------------------------------

// Simulation-only observer: flags an unknown select offered with in_valid.
module demux4_buf_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       in_valid,
  input logic [1:0] s
);

  // Report any cycle where the source offers a word with an X/Z select.
  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (!$isunknown(s))
        else $error("demux4_buf: select s is X/Z while in_valid is high; word not pushed");
    end
  end

endmodule

module demux4_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             ack0,
  input  logic             ack1,
  input  logic             ack2,
  input  logic             ack3,
  output logic             full0,
  output logic             full1,
  output logic             full2,
  output logic             full3
);

  // Per-channel FIFO storage: head is the oldest word, tail the younger one.
  logic [WIDTH-1:0] head_r     [4];
  logic [WIDTH-1:0] tail_r     [4];
  logic [1:0]       cnt_r      [4];
  logic [WIDTH-1:0] head_nxt_s [4];
  logic [WIDTH-1:0] tail_nxt_s [4];
  logic [1:0]       cnt_nxt_s  [4];

  // Registered output images.
  logic [WIDTH-1:0] o_r [4];
  logic [3:0]       v_r;
  logic [3:0]       full_r;

  // Handshake decode.
  logic [3:0]       ack_s;
  logic [3:0]       push_s;
  logic [3:0]       pop_s;
  logic             in_ready_s;

  assign ack_s = {ack3, ack2, ack1, ack0};

  // A pop needs a valid head; an ack against an empty channel is ignored.
  assign pop_s = ack_s & v_r;

  // Select decode and readiness. ack never feeds readiness, so a full channel
  // refuses a push even in a cycle where its sink is draining it. An unknown
  // select matches no arm and falls to the default: no push, not ready.
  always_comb begin
    push_s     = 4'b0000;
    in_ready_s = 1'b0;
    case (s)
      2'd0: begin
        in_ready_s = (cnt_r[0] < 2'd2);
        push_s[0]  = in_valid && in_ready_s;
      end
      2'd1: begin
        in_ready_s = (cnt_r[1] < 2'd2);
        push_s[1]  = in_valid && in_ready_s;
      end
      2'd2: begin
        in_ready_s = (cnt_r[2] < 2'd2);
        push_s[2]  = in_valid && in_ready_s;
      end
      2'd3: begin
        in_ready_s = (cnt_r[3] < 2'd2);
        push_s[3]  = in_valid && in_ready_s;
      end
      default: begin
        in_ready_s = 1'b0;
        push_s     = 4'b0000;
      end
    endcase
  end

  assign in_ready = in_ready_s;

  // Next-state of every channel FIFO from its own push/pop pair only.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      head_nxt_s[k] = head_r[k];
      tail_nxt_s[k] = tail_r[k];
      cnt_nxt_s[k]  = cnt_r[k];
      case (cnt_r[k])
        2'd0: begin
          // Empty: a pushed word goes straight to the head.
          if (push_s[k]) begin
            head_nxt_s[k] = i;
            cnt_nxt_s[k]  = 2'd1;
          end else begin
            cnt_nxt_s[k]  = 2'd0;
          end
        end
        2'd1: begin
          if (push_s[k] && pop_s[k]) begin
            // Old head leaves, new word becomes head; occupancy stays 1.
            head_nxt_s[k] = i;
            cnt_nxt_s[k]  = 2'd1;
          end else if (push_s[k]) begin
            tail_nxt_s[k] = i;
            cnt_nxt_s[k]  = 2'd2;
          end else if (pop_s[k]) begin
            cnt_nxt_s[k]  = 2'd0;
          end else begin
            cnt_nxt_s[k]  = 2'd1;
          end
        end
        2'd2: begin
          // Full channels are never ready, so only a pop can happen here.
          if (pop_s[k]) begin
            head_nxt_s[k] = tail_r[k];
            cnt_nxt_s[k]  = 2'd1;
          end else begin
            cnt_nxt_s[k]  = 2'd2;
          end
        end
        default: begin
          // Unreachable occupancy: fall back to empty rather than hold garbage.
          cnt_nxt_s[k] = 2'd0;
        end
      endcase
    end
  end

  // State and output registers; reset wins over any push or pop in the cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        head_r[k] <= {WIDTH{1'b0}};
        tail_r[k] <= {WIDTH{1'b0}};
        cnt_r[k]  <= 2'd0;
        o_r[k]    <= {WIDTH{1'b0}};
      end
      v_r    <= 4'b0000;
      full_r <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        head_r[k] <= head_nxt_s[k];
        tail_r[k] <= tail_nxt_s[k];
        cnt_r[k]  <= cnt_nxt_s[k];
        // Output images are built from next state so they line up with cnt_r.
        o_r[k]    <= (cnt_nxt_s[k] != 2'd0) ? head_nxt_s[k] : {WIDTH{1'b0}};
        v_r[k]    <= (cnt_nxt_s[k] != 2'd0);
        full_r[k] <= (cnt_nxt_s[k] == 2'd2);
      end
    end
  end

  assign o0    = o_r[0];
  assign o1    = o_r[1];
  assign o2    = o_r[2];
  assign o3    = o_r[3];
  assign v0    = v_r[0];
  assign v1    = v_r[1];
  assign v2    = v_r[2];
  assign v3    = v_r[3];
  assign full0 = full_r[0];
  assign full1 = full_r[1];
  assign full2 = full_r[2];
  assign full3 = full_r[3];

  demux4_buf_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .s        (s)
  );

endmodule
